// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared definitions for the universal counter: the 2-bit operation code type
// and the four operation encodings used by counter and counter_next.
// -----------------------------------------------------------------------------
package counter_pkg;

    // Operation select sampled at each rising clock edge.
    typedef logic [1:0] ctrl_t;

    localparam ctrl_t CTRL_HOLD = 2'b00;  // keep current count
    localparam ctrl_t CTRL_UP   = 2'b01;  // count + 1, wraps modulo 2^N
    localparam ctrl_t CTRL_DOWN = 2'b10;  // count - 1, wraps modulo 2^N
    localparam ctrl_t CTRL_LOAD = 2'b11;  // take parallel_in

endpackage : counter_pkg

// File: rtl/counter_next.sv
// -----------------------------------------------------------------------------
// counter_next
// Purely combinational next-count selector for the universal counter.
//
// Ports:
//   i_count        in   N  current registered count
//   i_control      in   2  operation select (HOLD / UP / DOWN / LOAD)
//   i_parallel_in  in   N  load value, only used for LOAD
//   o_next         out  N  value the count register takes on the next edge
// -----------------------------------------------------------------------------
module counter_next
    import counter_pkg::*;
#(
    parameter int N = 16
) (
    input  logic [N-1:0] i_count,
    input  ctrl_t        i_control,
    input  logic [N-1:0] i_parallel_in,
    output logic [N-1:0] o_next
);

    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven,
        // so no latch is inferred if a branch is ever left incomplete.
        o_next = i_count;
        case (i_control)
            CTRL_HOLD: o_next = i_count;
            CTRL_UP:   o_next = i_count + N'(1);  // truncation gives wrap to 0
            CTRL_DOWN: o_next = i_count - N'(1);  // truncation gives wrap to all-ones
            CTRL_LOAD: o_next = i_parallel_in;
            // An unknown control code holds the count instead of loading a
            // made-up value into the register.
            default:   o_next = i_count;
        endcase
    end

endmodule : counter_next

// File: rtl/counter.sv
// -----------------------------------------------------------------------------
// counter
// Parametric N-bit universal synchronous counter: hold, count up, count down
// and parallel load, selected per cycle by a 2-bit control code. The output
// is taken straight from the count register, so there is no combinational
// path from any input to count_out.
//
// Ports:
//   clk          in   1  clock, all updates on the rising edge
//   rst_n        in   1  asynchronous active-low reset, clears the count
//   control      in   2  operation select (see counter_pkg encodings)
//   parallel_in  in   N  load value, only used when control = LOAD
//   count_out    out  N  current count
// -----------------------------------------------------------------------------
module counter
    import counter_pkg::*;
#(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  ctrl_t        control,
    input  logic [N-1:0] parallel_in,
    output logic [N-1:0] count_out
);

    logic [N-1:0] r_count;
    logic [N-1:0] w_next;

    counter_next #(
        .N(N)
    ) u_next (
        .i_count       (r_count),
        .i_control     (control),
        .i_parallel_in (parallel_in),
        .o_next        (w_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its inputs from before the edge.
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_next;
        end
    end

    assign count_out = r_count;

endmodule : counter

// File: tb/tb_counter.sv
// -----------------------------------------------------------------------------
// tb_counter
// Self-checking bench for counter (N = 16). Directed steps follow the counter's
// documented behaviour, then a randomized run is compared against an integer
// reference model that applies the operation rules with plain modulo
// arithmetic. Outputs are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_counter;
    import counter_pkg::*;

    localparam int N       = 16;
    localparam int MODULUS = 1 << N;

    logic         clk;
    logic         rst_n;
    ctrl_t        control;
    logic [N-1:0] parallel_in;
    logic [N-1:0] count_out;

    int n_checks = 0;
    int n_passed = 0;
    int model    = 0;  // expected count, kept in range [0, 2^N)

    counter #(
        .N(N)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .control     (control),
        .parallel_in (parallel_in),
        .count_out   (count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_checks++;
        assert (obs === exp) n_passed++;
        else $error("FAIL %s: count_out=%h expected=%h", tag, obs, exp);
    endtask

    // Reference behaviour of one clock edge, written as integer arithmetic.
    function automatic int ref_next(input int cur, input logic [1:0] op, input logic [N-1:0] load);
        int nxt;
        case (op)
            2'd1:    nxt = (cur + 1) % MODULUS;
            2'd2:    nxt = (cur + MODULUS - 1) % MODULUS;
            2'd3:    nxt = int'(load);
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

    // Apply one operation over one rising edge and compare with the model.
    task automatic step(input logic [1:0] op, input logic [N-1:0] load, input string tag);
        logic [N-1:0] exp;
        control     = op;
        parallel_in = load;
        @(posedge clk);
        #1;
        if (rst_n) model = ref_next(model, op, load);
        else       model = 0;
        exp = model[N-1:0];
        check(tag, count_out, exp);
    endtask

    initial begin
        rst_n       = 1'b0;
        control     = CTRL_UP;
        parallel_in = '0;

        // Reset held for two edges while asking to count up.
        #1;
        check("rst_t0", count_out, 16'h0000);
        step(CTRL_UP, 16'h0000, "rst_edge1");
        check("rst_edge1_c", count_out, 16'h0000);
        step(CTRL_UP, 16'h0000, "rst_edge2");
        rst_n = 1'b1;
        step(CTRL_HOLD, 16'h0000, "rst_rel_hold");
        check("rst_rel_hold_c", count_out, 16'h0000);

        // Count up 1..5, then hold.
        for (int i = 1; i <= 5; i++) begin
            logic [N-1:0] e;
            e = N'(i);
            step(CTRL_UP, 16'h0000, "up");
            check("up_c", count_out, e);
        end
        for (int i = 0; i < 3; i++) begin
            step(CTRL_HOLD, 16'h0000, "hold");
            check("hold_c", count_out, 16'h0005);
        end

        // Load then count down through zero.
        step(CTRL_LOAD, 16'h0003, "load3");
        check("load3_c", count_out, 16'h0003);
        step(CTRL_DOWN, 16'h0000, "down");
        check("down2_c", count_out, 16'h0002);
        step(CTRL_DOWN, 16'h0000, "down");
        check("down1_c", count_out, 16'h0001);
        step(CTRL_DOWN, 16'h0000, "down");
        check("down0_c", count_out, 16'h0000);
        step(CTRL_DOWN, 16'h0000, "down_wrap");
        check("down_wrap_c", count_out, 16'hFFFF);

        // Overflow wrap.
        step(CTRL_LOAD, 16'hFFFE, "loadFFFE");
        check("loadFFFE_c", count_out, 16'hFFFE);
        step(CTRL_UP, 16'h0000, "up");
        check("upFFFF_c", count_out, 16'hFFFF);
        step(CTRL_UP, 16'h0000, "up_wrap");
        check("up_wrap_c", count_out, 16'h0000);
        step(CTRL_UP, 16'h0000, "up");
        check("up_after_wrap_c", count_out, 16'h0001);

        // parallel_in must be ignored unless LOAD.
        step(CTRL_HOLD, 16'hA5A5, "ign_hold");
        check("ign_hold_c", count_out, 16'h0001);
        step(CTRL_UP, 16'hA5A5, "ign_up");
        check("ign_up_c", count_out, 16'h0002);
        step(CTRL_DOWN, 16'hA5A5, "ign_down");
        check("ign_down_c", count_out, 16'h0001);
        step(CTRL_LOAD, 16'hA5A5, "load_A5A5");
        check("load_A5A5_c", count_out, 16'hA5A5);

        // Asynchronous reset between edges, with LOAD still requested.
        step(CTRL_LOAD, 16'h1234, "load1234");
        check("load1234_c", count_out, 16'h1234);
        #2 rst_n = 1'b0;
        #1;
        model = 0;
        check("async_rst", count_out, 16'h0000);
        step(CTRL_LOAD, 16'h5555, "rst_over_load");
        check("rst_over_load_c", count_out, 16'h0000);
        rst_n = 1'b1;
        step(CTRL_UP, 16'h0000, "post_rst_up");
        check("post_rst_up_c", count_out, 16'h0001);

        // Randomized operations against the reference model, with occasional
        // asynchronous reset pulses between edges.
        for (int i = 0; i < 400; i++) begin
            logic [1:0]   op;
            logic [N-1:0] val;
            op  = 2'($urandom_range(0, 3));
            val = N'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                #3 rst_n = 1'b0;
                #1;
                model = 0;
                check("rand_async_rst", count_out, 16'h0000);
                rst_n = 1'b1;
            end
            step(op, val, "rand");
        end

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule : tb_counter
